// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch queue between the PC/redirect logic and
// the decoder. Words come from boot ROM (one per cycle) or from SDRAM over a
// busy/ready handshake. A redirect reloads the fetch PC, flushes the queue and
// causes any in-flight SDRAM word to be discarded.
// Optional build macro: FETCH_BYPASS_EN -- an empty queue forwards the incoming
// word straight to the decoder in the same cycle.
module fetch_queue #(
  parameter int unsigned       ADDR_W   = 16,
  parameter int unsigned       INSTR_W  = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       boot_mode,
  input  logic                       redirect_valid,
  input  logic [ADDR_W-1:0]          redirect_addr,
  output logic [ADDR_W-1:0]          rom_addr,
  input  logic [INSTR_W-1:0]         rom_instr,
  output logic                       mem_req,
  output logic [ADDR_W-1:0]          mem_addr,
  input  logic                       mem_busy,
  input  logic                       mem_ready,
  input  logic [INSTR_W-1:0]         mem_instr,
  input  logic                       data_req,
  output logic                       out_valid,
  output logic [INSTR_W-1:0]         out_instr,
  output logic [ADDR_W-1:0]          out_pc,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] fill_level
);

  localparam int unsigned      PTR_W   = $clog2(DEPTH);
  localparam int unsigned      CNT_W   = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    WAIT    = 2'd2,
    DISCARD = 2'd3
  } fsm_t;

  fsm_t               state_r;
  fsm_t               state_s;
  logic [ADDR_W-1:0]  fetch_pc_r;
  logic [ADDR_W-1:0]  fetch_pc_s;
  logic [ADDR_W-1:0]  pc_mem_r    [DEPTH];
  logic [INSTR_W-1:0] instr_mem_r [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [CNT_W-1:0]   count_r;
  logic [CNT_W-1:0]   count_s;
  logic [CNT_W:0]     level_s;
  logic               head_valid_s;
  logic               full_s;
  logic               q_pop_s;
  logic               rom_push_s;
  logic               mem_push_s;
  logic               push_s;
  logic               write_s;
  logic               outstanding_s;
  logic               fetch_ok_s;
  logic               accept_s;
  logic [INSTR_W-1:0] push_instr_s;

  // Queue push/pop decisions; a redirect suppresses both.
  always_comb begin
    head_valid_s = (count_r != {CNT_W{1'b0}});
    full_s       = (count_r == DEPTH_C);
    q_pop_s      = head_valid_s & out_ready & ~redirect_valid;
    // When full the head is always valid, so out_ready alone means a pop frees a slot.
    rom_push_s   = boot_mode & (~full_s | out_ready) & ~redirect_valid;
    mem_push_s   = (state_r == WAIT) & mem_ready & ~redirect_valid;
    push_s       = rom_push_s | mem_push_s;
    if (rom_push_s) begin
      push_instr_s = rom_instr;
    end else begin
      push_instr_s = mem_instr;
    end
`ifdef FETCH_BYPASS_EN
    // A word forwarded to a ready decoder from an empty queue is never stored.
    write_s = push_s & ~(~head_valid_s & out_ready);
`else
    write_s = push_s;
`endif
    if (redirect_valid) begin
      count_s = {CNT_W{1'b0}};
    end else begin
      count_s = count_r + CNT_W'(write_s) - CNT_W'(q_pop_s);
    end
    if (redirect_valid) begin
      fetch_pc_s = redirect_addr;
    end else if (push_s) begin
      fetch_pc_s = fetch_pc_r + {{(ADDR_W-1){1'b0}}, 1'b1};
    end else begin
      fetch_pc_s = fetch_pc_r;
    end
  end

  // SDRAM fetch FSM next state; at most one request is ever outstanding.
  always_comb begin
    state_s       = state_r;
    outstanding_s = (state_r == WAIT) | (state_r == DISCARD);
    level_s       = {1'b0, count_r} + (CNT_W + 1)'(outstanding_s);
    fetch_ok_s    = ~boot_mode & ~data_req & ~redirect_valid & (level_s < {1'b0, DEPTH_C});
    accept_s      = (state_r == REQ) & ~redirect_valid & ~mem_busy;
    case (state_r)
      IDLE: begin
        if (fetch_ok_s) begin
          state_s = REQ;
        end else begin
          state_s = IDLE;
        end
      end
      REQ: begin
        if (redirect_valid) begin
          state_s = IDLE;
        end else if (accept_s) begin
          state_s = WAIT;
        end else begin
          state_s = REQ;
        end
      end
      WAIT: begin
        // A reply landing in the redirect cycle is simply dropped; otherwise wait for it.
        if (mem_ready) begin
          state_s = IDLE;
        end else if (redirect_valid) begin
          state_s = DISCARD;
        end else begin
          state_s = WAIT;
        end
      end
      DISCARD: begin
        if (mem_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DISCARD;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Control state: FSM, fetch PC, occupancy and circular-buffer pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      fetch_pc_r <= RESET_PC;
      count_r    <= {CNT_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      wr_ptr_r   <= {PTR_W{1'b0}};
    end else begin
      state_r    <= state_s;
      fetch_pc_r <= fetch_pc_s;
      count_r    <= count_s;
      if (redirect_valid) begin
        rd_ptr_r <= {PTR_W{1'b0}};
        wr_ptr_r <= {PTR_W{1'b0}};
      end else begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(q_pop_s);
        wr_ptr_r <= wr_ptr_r + PTR_W'(write_s);
      end
    end
  end

  // Queue storage: each entry keeps the word and the address it was fetched from.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        pc_mem_r[i]    <= {ADDR_W{1'b0}};
        instr_mem_r[i] <= {INSTR_W{1'b0}};
      end
    end else if (write_s) begin
      pc_mem_r[wr_ptr_r]    <= fetch_pc_r;
      instr_mem_r[wr_ptr_r] <= push_instr_s;
    end
  end

  // Decoder-facing head; zero when nothing is presented.
  always_comb begin
`ifdef FETCH_BYPASS_EN
    out_valid = head_valid_s | push_s;
`else
    out_valid = head_valid_s;
`endif
    if (head_valid_s) begin
      out_instr = instr_mem_r[rd_ptr_r];
      out_pc    = pc_mem_r[rd_ptr_r];
    end
`ifdef FETCH_BYPASS_EN
    else if (push_s) begin
      out_instr = push_instr_s;
      out_pc    = fetch_pc_r;
    end
`endif
    else begin
      out_instr = {INSTR_W{1'b0}};
      out_pc    = {ADDR_W{1'b0}};
    end
  end

  assign rom_addr   = fetch_pc_r;
  assign mem_addr   = fetch_pc_r;
  assign mem_req    = (state_r == REQ) & ~redirect_valid;
  assign fill_level = count_r;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed testbench for fetch_queue: ROM streaming, back-pressure, address
// wrap, SDRAM handshake, redirect during WAIT, data_req blocking, and reset
// in the middle of a transaction. Expected values are hand-derived.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        boot_mode;
  logic        redirect_valid;
  logic [15:0] redirect_addr;
  logic [15:0] rom_addr;
  logic [31:0] rom_instr;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_busy;
  logic        mem_ready;
  logic [31:0] mem_instr;
  logic        data_req;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [15:0] out_pc;
  logic        out_ready;
  logic [2:0]  fill_level;

  int n_cmp = 0;
  int n_err = 0;

  fetch_queue #(
    .ADDR_W(16), .INSTR_W(32), .DEPTH(4), .RESET_PC(16'h0000)
  ) dut (
    .clk(clk), .rst(rst), .boot_mode(boot_mode),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .rom_addr(rom_addr), .rom_instr(rom_instr),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_busy(mem_busy),
    .mem_ready(mem_ready), .mem_instr(mem_instr), .data_req(data_req),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
    .out_ready(out_ready), .fill_level(fill_level)
  );

  always #5 clk = ~clk;

  // ROM model: word at address a is a + 0x1000.
  assign rom_instr = {16'h0000, rom_addr} + 32'h0000_1000;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [15:0] exp_pc;
    rst = 1'b1; boot_mode = 1'b1; redirect_valid = 1'b0; redirect_addr = 16'h0000;
    mem_busy = 1'b0; mem_ready = 1'b0; mem_instr = 32'h0; data_req = 1'b0; out_ready = 1'b0;
    tick(); tick(); #2;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", out_valid); end
    n_cmp++; if (fill_level !== 3'd0) begin n_err++; $display("FAIL rst_fill: got %0d want 0", fill_level); end
    n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL rst_mem_req: got %b want 0", mem_req); end
    n_cmp++; if (rom_addr !== 16'h0000) begin n_err++; $display("FAIL rst_rom_addr: got %h want 0000", rom_addr); end
    n_cmp++; if (mem_addr !== 16'h0000) begin n_err++; $display("FAIL rst_mem_addr: got %h want 0000", mem_addr); end
    n_cmp++; if (out_instr !== 32'h0) begin n_err++; $display("FAIL rst_instr: got %h want 0", out_instr); end
    n_cmp++; if (out_pc !== 16'h0000) begin n_err++; $display("FAIL rst_pc: got %h want 0000", out_pc); end
    // Cycle 0 after release.
    tick(); rst = 1'b0; out_ready = 1'b1; #2;
`ifdef FETCH_BYPASS_EN
    n_cmp++; if (out_valid !== 1'b1 || out_pc !== 16'h0000) begin n_err++; $display("FAIL rom_c0: got v=%b pc=%h want v=1 pc=0000", out_valid, out_pc); end
`else
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rom_c0: got v=%b want v=0", out_valid); end
`endif
    for (int k = 1; k <= 6; k++) begin
      tick(); #2;
`ifdef FETCH_BYPASS_EN
      exp_pc = 16'(k);
`else
      exp_pc = 16'(k - 1);
`endif
      n_cmp++; if (out_valid !== 1'b1 || out_pc !== exp_pc || out_instr !== ({16'h0000, exp_pc} + 32'h0000_1000))
        begin n_err++; $display("FAIL rom_stream[%0d]: got v=%b pc=%h instr=%h want pc=%h", k, out_valid, out_pc, out_instr, exp_pc); end
    end
  endtask

  task automatic test_rom_backpressure();
    logic [15:0] exp_pc;
    tick(); redirect_valid = 1'b1; redirect_addr = 16'h0100; out_ready = 1'b0; #2;
    for (int k = 1; k <= 10; k++) begin
      tick(); redirect_valid = 1'b0; #2;
`ifndef FETCH_BYPASS_EN
      if (k == 1) begin
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL redir_flush_valid: got %b want 0", out_valid); end
      end
`endif
    end
    n_cmp++; if (fill_level !== 3'd4) begin n_err++; $display("FAIL bp_fill: got %0d want 4", fill_level); end
    n_cmp++; if (rom_addr !== 16'h0104) begin n_err++; $display("FAIL bp_rom_addr: got %h want 0104", rom_addr); end
    for (int j = 0; j < 8; j++) begin
      tick(); out_ready = 1'b1; #2;
      exp_pc = 16'h0100 + 16'(j);
      n_cmp++; if (out_pc !== exp_pc || out_instr !== ({16'h0000, exp_pc} + 32'h0000_1000) || fill_level !== 3'd4)
        begin n_err++; $display("FAIL bp_drain[%0d]: got pc=%h instr=%h fill=%0d want pc=%h fill=4", j, out_pc, out_instr, fill_level, exp_pc); end
    end
  endtask

  task automatic test_rom_wrap();
    logic [15:0] exp_seq [3];
    exp_seq[0] = 16'hFFFE; exp_seq[1] = 16'hFFFF; exp_seq[2] = 16'h0000;
    tick(); redirect_valid = 1'b1; redirect_addr = 16'hFFFE; #2;
    tick(); redirect_valid = 1'b0; #2;
`ifndef FETCH_BYPASS_EN
    tick(); #2;
`endif
    for (int j = 0; j < 3; j++) begin
      if (j > 0) begin tick(); #2; end
      n_cmp++; if (out_valid !== 1'b1 || out_pc !== exp_seq[j]) begin n_err++; $display("FAIL wrap[%0d]: got v=%b pc=%h want pc=%h", j, out_valid, out_pc, exp_seq[j]); end
    end
  endtask

  task automatic test_sdram_busy();
    tick(); redirect_valid = 1'b1; redirect_addr = 16'h0200; boot_mode = 1'b0; mem_busy = 1'b1; #2;
    tick(); redirect_valid = 1'b0; #2;
    n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL sd_idle_req: got %b want 0", mem_req); end
    for (int k = 0; k < 3; k++) begin
      tick(); #2;
      n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 16'h0200) begin n_err++; $display("FAIL sd_busy[%0d]: got req=%b addr=%h want req=1 addr=0200", k, mem_req, mem_addr); end
    end
    tick(); mem_busy = 1'b0; #2;
    n_cmp++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL sd_accept_req: got %b want 1", mem_req); end
    tick(); mem_busy = 1'b1; #2;
    n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL sd_wait_req: got %b want 0", mem_req); end
    tick(); mem_ready = 1'b1; mem_instr = 32'hDEADBEEF; #2;
`ifdef FETCH_BYPASS_EN
    n_cmp++; if (out_valid !== 1'b1 || out_instr !== 32'hDEADBEEF) begin n_err++; $display("FAIL sd_data: got v=%b instr=%h want DEADBEEF", out_valid, out_instr); end
`endif
    tick(); mem_ready = 1'b0; #2;
`ifndef FETCH_BYPASS_EN
    n_cmp++; if (out_valid !== 1'b1 || out_instr !== 32'hDEADBEEF || out_pc !== 16'h0200)
      begin n_err++; $display("FAIL sd_data: got v=%b instr=%h pc=%h want DEADBEEF at 0200", out_valid, out_instr, out_pc); end
`endif
  endtask

  task automatic test_redirect_wait();
    bit seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      tick(); #2;
      if (mem_req === 1'b1) seen = 1'b1;
    end
    n_cmp++; if (!seen) begin n_err++; $display("FAIL rw_req_timeout: got no mem_req want mem_req within 10 cycles"); end
    tick(); mem_busy = 1'b0; #2;
    tick(); mem_busy = 1'b1; #2;
    n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL rw_wait_req: got %b want 0", mem_req); end
    tick(); redirect_valid = 1'b1; redirect_addr = 16'h0040; #2;
    tick(); redirect_valid = 1'b0; #2;
    n_cmp++; if (out_valid !== 1'b0 || mem_req !== 1'b0 || fill_level !== 3'd0)
      begin n_err++; $display("FAIL rw_flush: got v=%b req=%b fill=%0d want 0/0/0", out_valid, mem_req, fill_level); end
    tick(); mem_ready = 1'b1; mem_instr = 32'hBADBAD00; #2;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rw_drop_now: got v=%b want 0", out_valid); end
    tick(); mem_ready = 1'b0; #2;
    n_cmp++; if (out_valid !== 1'b0 || fill_level !== 3'd0) begin n_err++; $display("FAIL rw_drop_after: got v=%b fill=%0d want 0/0", out_valid, fill_level); end
    tick(); mem_busy = 1'b0; #2;
    n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 16'h0040) begin n_err++; $display("FAIL rw_new_req: got req=%b addr=%h want 1/0040", mem_req, mem_addr); end
    tick(); mem_busy = 1'b1; #2;
    tick(); mem_ready = 1'b1; mem_instr = 32'h12345678; #2;
`ifdef FETCH_BYPASS_EN
    n_cmp++; if (out_valid !== 1'b1 || out_pc !== 16'h0040 || out_instr !== 32'h12345678)
      begin n_err++; $display("FAIL rw_first_pc: got v=%b pc=%h instr=%h want 0040/12345678", out_valid, out_pc, out_instr); end
`endif
    tick(); mem_ready = 1'b0; #2;
`ifndef FETCH_BYPASS_EN
    n_cmp++; if (out_valid !== 1'b1 || out_pc !== 16'h0040 || out_instr !== 32'h12345678)
      begin n_err++; $display("FAIL rw_first_pc: got v=%b pc=%h instr=%h want 0040/12345678", out_valid, out_pc, out_instr); end
`endif
  endtask

  task automatic test_data_req();
    tick(); data_req = 1'b1; redirect_valid = 1'b1; redirect_addr = 16'h0300; #2;
    for (int k = 0; k < 4; k++) begin
      tick(); redirect_valid = 1'b0; #2;
      n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL dr_block[%0d]: got %b want 0", k, mem_req); end
    end
    tick(); data_req = 1'b0; #2;
    n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL dr_fall: got %b want 0", mem_req); end
    tick(); #2;
    n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 16'h0300) begin n_err++; $display("FAIL dr_resume: got req=%b addr=%h want 1/0300", mem_req, mem_addr); end
  endtask

  task automatic test_reset_mid();
    tick(); mem_busy = 1'b0; #2;
    tick(); mem_busy = 1'b1; rst = 1'b1; #2;
    n_cmp++; if (mem_req !== 1'b0 || fill_level !== 3'd0 || out_valid !== 1'b0 || mem_addr !== 16'h0000)
      begin n_err++; $display("FAIL mid_rst: got req=%b fill=%0d v=%b addr=%h want 0/0/0/0000", mem_req, fill_level, out_valid, mem_addr); end
    tick(); rst = 1'b0; data_req = 1'b1; #2;
    tick(); mem_ready = 1'b1; mem_instr = 32'hCAFEF00D; #2;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stale_ready_now: got v=%b want 0", out_valid); end
    tick(); mem_ready = 1'b0; #2;
    n_cmp++; if (out_valid !== 1'b0 || fill_level !== 3'd0) begin n_err++; $display("FAIL stale_ready_after: got v=%b fill=%0d want 0/0", out_valid, fill_level); end
  endtask

  initial begin
    test_reset();
    test_rom_backpressure();
    test_rom_wrap();
    test_sdram_busy();
    test_redirect_wait();
    test_data_req();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion want finish before 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
